gray_frame_arbiter: RTL and testbench
=====================================

Name: gray_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one RGB565-to-grayscale converter between two RGB565 pixel sources (s0, s1).
- Grants a whole frame (sop..eop) to one source, back-pressures the other, and drives the converter's din/din_vld/din_sop/din_eop from registers.
- Tags every pixel with its source ID, aligned both to the converter input and to its 1-cycle-latency gray output.
- Polices frame framing: early sop, oversize frames and stalled frames are force-closed so the downstream edge-detection pipeline always sees a terminated frame.

Parameters:
- MAX_PIX, 307200, maximum pixels per frame (640x480); counter width $clog2(MAX_PIX+1).
- TIMEOUT, 1024, consecutive cycles with no granted-source beat inside a frame before abort; counter width $clog2(TIMEOUT+1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- s0_din, input, 16, source 0 pixel (R[15:11], G[10:5], B[4:0]).
- s0_vld / s0_sop / s0_eop, input, 1 each, source 0 valid, first pixel of frame, last pixel of frame.
- s0_rdy, output, 1, source 0 beat accepted when s0_vld & s0_rdy.
- s1_din, s1_vld, s1_sop, s1_eop, s1_rdy: same as s0 for source 1.
- cv_din, output, 16, pixel to converter.
- cv_vld / cv_sop / cv_eop, output, 1 each, to converter din_vld / din_sop / din_eop.
- cv_src, output, 1, source ID of the beat on cv_*.
- gray_src, output, 1, cv_src delayed 1 cycle; aligned with the converter's dout.
- busy, output, 1, high while a frame is granted.
- err_vld, output, 1, one-cycle error pulse.
- err_code, output, 2, 1 = sop mid-frame, 2 = MAX_PIX reached, 3 = timeout; held until the next error.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state = IDLE, grant = 0, last = 1 (s0 wins the first tie).
  - pix_cnt and to_cnt = 0.
  - All cv_*, cv_src, gray_src, busy, err_vld and err_code = 0.
  - Reset mid-frame truncates the frame: no eop is emitted.
- sX_rdy is combinational:
  - Asserted for the granted source in LOCK.
  - Also asserted for any source that is not currently granted and presents vld & !sop. That stray beat is discarded silently.
- IDLE state:
  - A request is sX_vld & sX_sop (the beat is held by the source).
  - One request: grant it. Both requesting: grant ~last. Go to LOCK next cycle.
  - No source beat is accepted in IDLE, so there is at least 1 arbitration cycle between frames.
- LOCK state, accepted beat handling:
  - Each accepted beat is registered to cv_din, cv_sop, cv_eop, with cv_vld = 1 and cv_src = grant. Latency is 1 cycle.
  - cv_vld = 0 in any cycle with no accepted beat or synthesized beat.
  - pix_cnt increments per accepted beat. to_cnt clears on an accepted beat and increments otherwise.
- LOCK state, exits (same edge as the closing beat: state goes to IDLE, last = grant, pix_cnt and to_cnt cleared):
  - Normal: accepted beat with eop.
  - Sop mid-frame (sop on a beat that is not the first): beat forwarded with cv_sop = 0 and cv_eop = 1; err_code = 1.
  - Oversize: accepted beat makes pix_cnt = MAX_PIX without eop. Beat forwarded with cv_eop forced to 1; err_code = 2. Any remaining non-sop beats from that source are then drained as stray beats.
  - Timeout: to_cnt reaches TIMEOUT. A synthesized beat is emitted: cv_vld = 1, cv_din = 0, cv_sop = 0, cv_eop = 1, cv_src = grant; err_code = 3.
  - Exit priority when events coincide: sop-error > MAX_PIX > eop. An eop on the MAX_PIX-th beat is a normal close with no error.
- A single-pixel frame (sop & eop on the same beat) is legal: cv_sop = cv_eop = 1 on one beat.
- busy = (state == LOCK), registered.
- gray_src updates every cycle from cv_src.

Test Plan:
- Frame fidelity and timing.
  - Stimulus: s0 frame of 4 beats 0xF800, 0x07E0, 0x001F, 0xFFFF (sop on beat 1, eop on beat 4).
  - Required: s0_rdy high 4 cycles starting 1 cycle after the request. cv_* carry identical data 1 cycle after each accept, cv_sop on 0xF800 only, cv_eop on 0xFFFF only. cv_src = 0; gray_src = 0 one cycle later.
- Round-robin fairness.
  - Stimulus: s0 and s1 both request in the first cycle after reset, each with 3-pixel frames, re-requesting immediately.
  - Required: grant order s0, s1, s0, s1. Exactly 1 IDLE cycle between frames. The non-granted source's rdy stays 0 while it holds sop.
- Oversize abort.
  - Stimulus: MAX_PIX = 8; s1 sends 10 beats with no eop.
  - Required: 8th beat has cv_eop = 1; err_vld pulses with err_code = 2. Beats 9 and 10 are accepted-and-dropped with cv_vld = 0.
- Timeout abort.
  - Stimulus: TIMEOUT = 16; s1 sends sop plus 2 pixels, then vld = 0.
  - Required: 16 cycles later a synthesized beat appears (cv_din = 0x0000, cv_eop = 1, cv_src = 1); err_code = 3; busy falls the next cycle.
- Sop mid-frame.
  - Stimulus: s0 sends sop, pixel, then a beat with sop = 1.
  - Required: third beat forwarded with cv_sop = 0 and cv_eop = 1; err_code = 1. The source's next sop starts a new grant.
- Reset mid-frame.
  - Stimulus: rst = 1 for 1 cycle during pixel 2 of an s1 frame, with s0 and s1 both then requesting.
  - Required: all outputs 0 the cycle after reset, no cv_eop emitted. s0 is granted first after reset.

Source files
------------

// File: rtl/gray_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one RGB565->gray converter between two sources.
// Grants whole frames, tags beats with source ID and force-closes malformed or stalled frames.
module gray_frame_arbiter #(
  parameter int MAX_PIX = 307200,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s0_din,
  input  logic        s0_vld,
  input  logic        s0_sop,
  input  logic        s0_eop,
  output logic        s0_rdy,
  input  logic [15:0] s1_din,
  input  logic        s1_vld,
  input  logic        s1_sop,
  input  logic        s1_eop,
  output logic        s1_rdy,
  output logic [15:0] cv_din,
  output logic        cv_vld,
  output logic        cv_sop,
  output logic        cv_eop,
  output logic        cv_src,
  output logic        gray_src,
  output logic        busy,
  output logic        err_vld,
  output logic [1:0]  err_code
);
  localparam int PW = $clog2(MAX_PIX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d, last_q, last_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]     cv_din_q, cv_din_d;
  logic            cv_vld_q, cv_vld_d, cv_sop_q, cv_sop_d, cv_eop_q, cv_eop_d;
  logic            cv_src_q, cv_src_d, gray_src_q, gray_src_d, busy_q, busy_d;
  logic            err_vld_q, err_vld_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            lock, lock0, lock1, req0, req1;
  logic [15:0]     g_din;
  logic            g_vld, g_sop, g_eop, acc, first, sop_err, max_hit, tmo, close;
  logic [PW-1:0]   pix_inc;
  logic [TW-1:0]   to_inc;

  assign lock  = (state_q == LOCK);
  assign lock0 = lock & ~grant_q;
  assign lock1 = lock &  grant_q;
  // Non-granted sources may dump non-sop beats so a truncated frame's tail drains.
  assign s0_rdy = lock0 | (s0_vld & ~s0_sop);
  assign s1_rdy = lock1 | (s1_vld & ~s1_sop);
  assign req0   = s0_vld & s0_sop;
  assign req1   = s1_vld & s1_sop;

  assign g_din   = grant_q ? s1_din : s0_din;
  assign g_vld   = grant_q ? s1_vld : s0_vld;
  assign g_sop   = grant_q ? s1_sop : s0_sop;
  assign g_eop   = grant_q ? s1_eop : s0_eop;
  assign acc     = lock & g_vld;
  assign first   = (pix_cnt_q == '0);
  assign pix_inc = pix_cnt_q + 1'b1;
  assign to_inc  = to_cnt_q + 1'b1;
  assign sop_err = acc & g_sop & ~first;
  assign max_hit = acc & ~sop_err & ~g_eop & (pix_inc == PW'(MAX_PIX));
  assign tmo     = lock & ~acc & (to_inc == TW'(TIMEOUT));
  assign close   = (acc & (g_eop | sop_err | max_hit)) | tmo;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pix_cnt_d  = pix_cnt_q;
    to_cnt_d   = to_cnt_q;
    cv_din_d   = cv_din_q;
    cv_vld_d   = 1'b0;
    cv_sop_d   = 1'b0;
    cv_eop_d   = 1'b0;
    cv_src_d   = cv_src_q;
    err_vld_d  = 1'b0;
    err_code_d = err_code_q;
    gray_src_d = cv_src_q;
    busy_d     = lock;
    if (!lock) begin
      if (req0 | req1) begin
        state_d = LOCK;
        grant_d = (req0 & req1) ? ~last_q : req1;
      end
    end else begin
      if (acc) begin
        cv_vld_d  = 1'b1;
        cv_din_d  = g_din;
        cv_sop_d  = g_sop & first;
        cv_eop_d  = g_eop | sop_err | max_hit;
        cv_src_d  = grant_q;
        pix_cnt_d = pix_inc;
        to_cnt_d  = '0;
        if (sop_err) begin
          err_vld_d = 1'b1; err_code_d = 2'd1;
        end else if (max_hit) begin
          err_vld_d = 1'b1; err_code_d = 2'd2;
        end
      end else if (tmo) begin
        cv_vld_d   = 1'b1;
        cv_din_d   = 16'h0000;
        cv_eop_d   = 1'b1;
        cv_src_d   = grant_q;
        err_vld_d  = 1'b1;
        err_code_d = 2'd3;
      end else begin
        to_cnt_d = to_inc;
      end
      if (close) begin
        state_d   = IDLE;
        last_d    = grant_q;
        pix_cnt_d = '0;
        to_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      pix_cnt_q  <= '0;
      to_cnt_q   <= '0;
      cv_din_q   <= '0;
      cv_vld_q   <= 1'b0;
      cv_sop_q   <= 1'b0;
      cv_eop_q   <= 1'b0;
      cv_src_q   <= 1'b0;
      gray_src_q <= 1'b0;
      busy_q     <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      pix_cnt_q  <= pix_cnt_d;
      to_cnt_q   <= to_cnt_d;
      cv_din_q   <= cv_din_d;
      cv_vld_q   <= cv_vld_d;
      cv_sop_q   <= cv_sop_d;
      cv_eop_q   <= cv_eop_d;
      cv_src_q   <= cv_src_d;
      gray_src_q <= gray_src_d;
      busy_q     <= busy_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
    end
  end

  assign cv_din   = cv_din_q;
  assign cv_vld   = cv_vld_q;
  assign cv_sop   = cv_sop_q;
  assign cv_eop   = cv_eop_q;
  assign cv_src   = cv_src_q;
  assign gray_src = gray_src_q;
  assign busy     = busy_q;
  assign err_vld  = err_vld_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_gray_frame_arbiter.sv
// Bench for gray_frame_arbiter: directed framing scenarios plus randomized two-source traffic
// scored against a frame-level model (strict alternation, one arbitration cycle between frames).
module tb_gray_frame_arbiter;
  localparam int MAXP = 8, TMO = 16, NFMAX = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] s0_din = '0, s1_din = '0;
  logic        s0_vld = 0, s0_sop = 0, s0_eop = 0, s0_rdy;
  logic        s1_vld = 0, s1_sop = 0, s1_eop = 0, s1_rdy;
  logic [15:0] cv_din;
  logic        cv_vld, cv_sop, cv_eop, cv_src, gray_src, busy, err_vld;
  logic [1:0]  err_code;

  int n_chk = 0, n_pass = 0, cyc = 0;

  typedef struct { int cyc; logic src; logic [15:0] din; logic sop; logic eop; } beat_t;
  beat_t       obs[$];
  int          fr_len [2][NFMAX];
  logic [15:0] fr_pix [2][NFMAX][MAXP];
  int          fr_gap [2][NFMAX][MAXP];
  int          sop_viol, err_seen, trf_fail;

  gray_frame_arbiter #(.MAX_PIX(MAXP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .s0_din(s0_din), .s0_vld(s0_vld), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_rdy(s0_rdy),
    .s1_din(s1_din), .s1_vld(s1_vld), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_rdy(s1_rdy),
    .cv_din(cv_din), .cv_vld(cv_vld), .cv_sop(cv_sop), .cv_eop(cv_eop), .cv_src(cv_src),
    .gray_src(gray_src), .busy(busy), .err_vld(err_vld), .err_code(err_code));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(); @(posedge clk); #1; endtask

  task automatic set_src(input int x, input logic v, s, e, input logic [15:0] d);
    if (x == 0) begin s0_vld = v; s0_sop = s; s0_eop = e; s0_din = d; end
    else        begin s1_vld = v; s1_sop = s; s1_eop = e; s1_din = d; end
  endtask

  task automatic idle_inputs(); set_src(0, 0, 0, 0, 16'h0); set_src(1, 0, 0, 0, 16'h0); endtask
  task automatic do_reset(); idle_inputs(); rst = 1'b1; step(); rst = 1'b0; endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1;
    set_src(0, 1, 1, 0, 16'h1234);
    step(); step();
    @(negedge clk);
    n_chk++;
    if ({cv_din, cv_vld, cv_sop, cv_eop, cv_src, gray_src, busy, err_vld, err_code} !== 25'd0)
      $display("FAIL reset_outputs got din=%h vld=%b busy=%b err=%b/%0d want all 0", cv_din, cv_vld, busy, err_vld, err_code);
    else n_pass++;
    n_chk++; if (s0_rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", s0_rdy); else n_pass++;
    step(); rst = 1'b0; idle_inputs();
  endtask

  task automatic test_frame();
    logic [15:0] px [4];
    px = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    do_reset();
    set_src(0, 1, 1, 0, px[0]);
    @(negedge clk);
    n_chk++; if (s0_rdy !== 1'b0) $display("FAIL frm_req_rdy got %b want 0", s0_rdy); else n_pass++;
    step();
    for (int i = 0; i < 4; i++) begin
      set_src(0, 1, i == 0, i == 3, px[i]);
      @(negedge clk);
      n_chk++; if (s0_rdy !== 1'b1) $display("FAIL frm_rdy beat%0d got %b want 1", i, s0_rdy); else n_pass++;
      if (i > 0) begin
        n_chk++;
        if ({cv_vld, cv_din, cv_sop, cv_eop, cv_src} !== {1'b1, px[i-1], i == 1, 1'b0, 1'b0})
          $display("FAIL frm_cv beat%0d got v=%b d=%h s=%b e=%b src=%b want d=%h", i-1, cv_vld, cv_din, cv_sop, cv_eop, cv_src, px[i-1]);
        else n_pass++;
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({cv_vld, cv_din, cv_sop, cv_eop, cv_src, s0_rdy} !== {1'b1, px[3], 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL frm_last got v=%b d=%h s=%b e=%b src=%b rdy=%b want d=ffff eop", cv_vld, cv_din, cv_sop, cv_eop, cv_src, s0_rdy);
    else n_pass++;
    step();
    @(negedge clk);
    n_chk++;
    if ({cv_vld, gray_src} !== 2'b00) $display("FAIL frm_after got vld=%b gray_src=%b want 0 0", cv_vld, gray_src);
    else n_pass++;
  endtask

  // Drives both sources from the frame tables; records converter beats and handshake anomalies.
  task automatic run_traffic(input int nf);
    int f [2], b [2], gap [2];
    bit done [2], v [2], sp [2], ep [2], acc [2], rdy [2];
    int exp_next, guard, tail;
    obs.delete(); sop_viol = 0; err_seen = 0; trf_fail = 0;
    exp_next = 0; guard = 0; tail = 0;
    for (int x = 0; x < 2; x++) begin f[x] = 0; b[x] = 0; gap[x] = 0; done[x] = 0; end
    while (tail < 4 && guard < 3000) begin
      for (int x = 0; x < 2; x++) begin
        v[x]  = !done[x] && gap[x] == 0;
        sp[x] = v[x] && b[x] == 0;
        ep[x] = v[x] && b[x] == fr_len[x][f[x]] - 1;
        set_src(x, v[x], sp[x], ep[x], v[x] ? fr_pix[x][f[x]][b[x]] : 16'h0);
      end
      @(negedge clk);
      rdy[0] = s0_rdy; rdy[1] = s1_rdy;
      for (int x = 0; x < 2; x++) begin
        acc[x] = v[x] && rdy[x];
        if (sp[x] && rdy[x]) begin
          if (x != exp_next) sop_viol++;
          exp_next = 1 - x;
        end
      end
      if (cv_vld) obs.push_back('{cyc, cv_src, cv_din, cv_sop, cv_eop});
      if (err_vld) err_seen++;
      step();
      for (int x = 0; x < 2; x++) begin
        if (acc[x]) begin
          b[x]++;
          if (b[x] == fr_len[x][f[x]]) begin
            b[x] = 0; f[x]++;
            if (f[x] == nf) done[x] = 1;
          end
          gap[x] = (b[x] == 0) ? 0 : fr_gap[x][f[x]][b[x]];
        end else if (gap[x] > 0) gap[x]--;
      end
      if (done[0] && done[1]) tail++;
      guard++;
    end
    idle_inputs();
    if (guard >= 3000) begin
      trf_fail = 1;
      n_chk++; $display("FAIL traffic_timeout got %0d cycles want completion", guard);
    end
  endtask

  task automatic test_round_robin();
    int k, total;
    for (int x = 0; x < 2; x++)
      for (int fr = 0; fr < 2; fr++) begin
        fr_len[x][fr] = 3;
        for (int bb = 0; bb < MAXP; bb++) begin
          fr_pix[x][fr][bb] = 16'(16'h1000 * (x + 1) + 16'h0100 * fr + bb);
          fr_gap[x][fr][bb] = 0;
        end
      end
    do_reset();
    run_traffic(2);
    total = 12; k = 0;
    n_chk++; if (obs.size() != total) $display("FAIL rr_count got %0d want %0d", obs.size(), total); else n_pass++;
    for (int fi = 0; fi < 4; fi++) begin
      int x, fr;
      x = fi % 2; fr = fi / 2;
      for (int bb = 0; bb < fr_len[x][fr]; bb++) begin
        if (k < obs.size()) begin
          n_chk++;
          if (obs[k].src !== 1'(x) || obs[k].din !== fr_pix[x][fr][bb] || obs[k].sop !== (bb == 0) || obs[k].eop !== (bb == 2))
            $display("FAIL rr_beat%0d got src=%b d=%h s=%b e=%b want src=%0d d=%h", k, obs[k].src, obs[k].din, obs[k].sop, obs[k].eop, x, fr_pix[x][fr][bb]);
          else n_pass++;
          if (bb == 0 && k > 0) begin
            n_chk++;
            if (obs[k].cyc - obs[k-1].cyc != 2) $display("FAIL rr_gap frame%0d got %0d want 2", fi, obs[k].cyc - obs[k-1].cyc);
            else n_pass++;
          end
        end
        k++;
      end
    end
    n_chk++; if (sop_viol != 0) $display("FAIL rr_grant_order got %0d bad grants want 0", sop_viol); else n_pass++;
  endtask

  task automatic test_random();
    int k, total, nf;
    nf = 6; total = 0;
    for (int x = 0; x < 2; x++)
      for (int fr = 0; fr < nf; fr++) begin
        fr_len[x][fr] = $urandom_range(1, MAXP);
        for (int bb = 0; bb < MAXP; bb++) begin
          fr_pix[x][fr][bb] = 16'($urandom);
          fr_gap[x][fr][bb] = $urandom_range(0, 3);
        end
      end
    fr_len[0][0] = MAXP; fr_len[1][0] = 1;
    for (int x = 0; x < 2; x++) for (int fr = 0; fr < nf; fr++) total += fr_len[x][fr];
    do_reset();
    run_traffic(nf);
    k = 0;
    n_chk++; if (obs.size() != total) $display("FAIL rnd_count got %0d want %0d", obs.size(), total); else n_pass++;
    for (int fi = 0; fi < 2 * nf; fi++) begin
      int x, fr;
      x = fi % 2; fr = fi / 2;
      for (int bb = 0; bb < fr_len[x][fr]; bb++) begin
        if (k < obs.size()) begin
          n_chk++;
          if (obs[k].src !== 1'(x) || obs[k].din !== fr_pix[x][fr][bb] || obs[k].sop !== (bb == 0) || obs[k].eop !== (bb == fr_len[x][fr] - 1))
            $display("FAIL rnd_beat%0d got src=%b d=%h s=%b e=%b want src=%0d d=%h", k, obs[k].src, obs[k].din, obs[k].sop, obs[k].eop, x, fr_pix[x][fr][bb]);
          else n_pass++;
        end
        k++;
      end
    end
    n_chk++; if (sop_viol != 0) $display("FAIL rnd_grant_order got %0d bad grants want 0", sop_viol); else n_pass++;
    n_chk++; if (err_seen != 0) $display("FAIL rnd_errors got %0d err pulses want 0", err_seen); else n_pass++;
  endtask

  task automatic test_oversize();
    do_reset();
    set_src(1, 1, 1, 0, 16'hA000);
    step();
    for (int i = 0; i < 10; i++) begin
      set_src(1, 1, i == 0, 0, 16'(16'hA000 + i));
      @(negedge clk);
      n_chk++; if (s1_rdy !== 1'b1) $display("FAIL ovs_rdy beat%0d got %b want 1", i, s1_rdy); else n_pass++;
      if (i >= 1 && i <= 8) begin
        n_chk++;
        if ({cv_vld, cv_din, cv_eop, cv_src, err_vld} !== {1'b1, 16'(16'hA000 + i - 1), i == 8, 1'b1, i == 8})
          $display("FAIL ovs_cv beat%0d got v=%b d=%h e=%b src=%b err=%b", i-1, cv_vld, cv_din, cv_eop, cv_src, err_vld);
        else n_pass++;
      end else if (i == 9) begin
        n_chk++; if (cv_vld !== 1'b0) $display("FAIL ovs_drop9 got vld=%b want 0", cv_vld); else n_pass++;
      end
      if (i == 8) begin
        n_chk++; if (err_code !== 2'd2) $display("FAIL ovs_code got %0d want 2", err_code); else n_pass++;
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({cv_vld, err_vld, err_code} !== {1'b0, 1'b0, 2'd2})
      $display("FAIL ovs_drop10 got vld=%b err=%b code=%0d want 0 0 2", cv_vld, err_vld, err_code);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int lat;
    do_reset();
    set_src(1, 1, 1, 0, 16'hB000);
    step();
    for (int i = 0; i < 3; i++) begin set_src(1, 1, i == 0, 0, 16'(16'hB000 + i)); step(); end
    idle_inputs();
    @(negedge clk);
    n_chk++; if ({cv_vld, cv_din} !== {1'b1, 16'hB002}) $display("FAIL tmo_last got v=%b d=%h want 1 b002", cv_vld, cv_din); else n_pass++;
    lat = 0;
    do begin step(); @(negedge clk); lat++; end while (!cv_vld && lat < 40);
    n_chk++; if (lat != 16) $display("FAIL tmo_latency got %0d want 16", lat); else n_pass++;
    n_chk++;
    if ({cv_vld, cv_din, cv_sop, cv_eop, cv_src, err_vld, err_code, busy} !== {1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1})
      $display("FAIL tmo_beat got d=%h s=%b e=%b src=%b err=%b code=%0d busy=%b", cv_din, cv_sop, cv_eop, cv_src, err_vld, err_code, busy);
    else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if ({busy, cv_vld, err_vld} !== 3'b000) $display("FAIL tmo_after got busy=%b vld=%b err=%b want 000", busy, cv_vld, err_vld); else n_pass++;
  endtask

  task automatic test_sop_mid();
    do_reset();
    set_src(0, 1, 1, 0, 16'hC000); step();
    set_src(0, 1, 1, 0, 16'hC000); step();
    set_src(0, 1, 0, 0, 16'hC001);
    @(negedge clk);
    n_chk++; if ({cv_vld, cv_din, cv_sop, cv_eop} !== {1'b1, 16'hC000, 1'b1, 1'b0}) $display("FAIL sop_first got d=%h s=%b e=%b", cv_din, cv_sop, cv_eop); else n_pass++;
    step();
    set_src(0, 1, 1, 0, 16'hC002);
    @(negedge clk);
    n_chk++; if (s0_rdy !== 1'b1) $display("FAIL sop_mid_rdy got %b want 1", s0_rdy); else n_pass++;
    step();
    set_src(0, 1, 1, 1, 16'hC003);
    @(negedge clk);
    n_chk++;
    if ({cv_vld, cv_din, cv_sop, cv_eop, err_vld, err_code, s0_rdy} !== {1'b1, 16'hC002, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0})
      $display("FAIL sop_close got d=%h s=%b e=%b err=%b code=%0d rdy=%b", cv_din, cv_sop, cv_eop, err_vld, err_code, s0_rdy);
    else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if (s0_rdy !== 1'b1) $display("FAIL sop_regrant got %b want 1", s0_rdy); else n_pass++;
    step();
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if ({cv_vld, cv_din, cv_sop, cv_eop, err_vld, err_code} !== {1'b1, 16'hC003, 1'b1, 1'b1, 1'b0, 2'd1})
      $display("FAIL sop_single got d=%h s=%b e=%b err=%b code=%0d", cv_din, cv_sop, cv_eop, err_vld, err_code);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(1, 1, 1, 0, 16'hD000); step();
    set_src(1, 1, 1, 0, 16'hD000); step();
    set_src(1, 1, 0, 0, 16'hD001); rst = 1'b1; step(); rst = 1'b0;
    set_src(0, 1, 1, 1, 16'hE000); set_src(1, 1, 1, 0, 16'hD100);
    @(negedge clk);
    n_chk++;
    if ({cv_din, cv_vld, cv_sop, cv_eop, cv_src, gray_src, busy, err_vld, err_code, s0_rdy, s1_rdy} !== 27'd0)
      $display("FAIL rstmid_outputs got d=%h v=%b e=%b busy=%b rdy=%b%b want all 0", cv_din, cv_vld, cv_eop, busy, s0_rdy, s1_rdy);
    else n_pass++;
    step();
    @(negedge clk);
    n_chk++; if ({s0_rdy, s1_rdy} !== 2'b10) $display("FAIL rstmid_grant got rdy0=%b rdy1=%b want 1 0", s0_rdy, s1_rdy); else n_pass++;
    step();
    set_src(0, 0, 0, 0, 16'h0);
    @(negedge clk);
    n_chk++;
    if ({cv_vld, cv_din, cv_sop, cv_eop, cv_src} !== {1'b1, 16'hE000, 1'b1, 1'b1, 1'b0})
      $display("FAIL rstmid_first got d=%h s=%b e=%b src=%b", cv_din, cv_sop, cv_eop, cv_src);
    else n_pass++;
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_round_robin();
    test_oversize();
    test_timeout();
    test_sop_mid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
